// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-requester memory arbiter: FSM state
// encodings, default bus widths and the burst beat-count rule.
// No ports (package).
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arbState_e;

    // A burst length field of 0 still moves one beat; anything else is
    // taken literally.
    function automatic int unsigned beatCount(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles both requester-side channels (packed {r1,r0}) and the single
// downstream memory channel.
// Modports:
//   slave  - the arbiter's view (takes requester traffic, drives memory)
//   master - the environment's view (requesters plus memory model)
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    logic [1:0]          m_req_valid;
    logic [1:0]          m_req_ready;
    logic [2*LEN_W-1:0]  m_req_len;
    logic [7:0]          m_req_mask;
    logic [2*ADDR_W-1:0] m_req_addr;
    logic [1:0]          m_req_we;
    logic [1:0]          m_write_valid;
    logic [2*DATA_W-1:0] m_write_data;
    logic [1:0]          m_read_valid;
    logic [DATA_W-1:0]   m_read_data;
    logic [1:0]          m_read_ack;

    logic                s_req_valid;
    logic                s_req_ready;
    logic [LEN_W-1:0]    s_req_len;
    logic [3:0]          s_req_mask;
    logic [ADDR_W-1:0]   s_req_addr;
    logic                s_req_we;
    logic                s_write_valid;
    logic [DATA_W-1:0]   s_write_data;
    logic                s_read_valid;
    logic [DATA_W-1:0]   s_read_data;
    logic                s_read_ack;

    modport slave (
        input  m_req_valid, m_req_len, m_req_mask, m_req_addr, m_req_we,
               m_write_valid, m_write_data, m_read_ack,
               s_req_ready, s_read_valid, s_read_data,
        output m_req_ready, m_read_valid, m_read_data,
               s_req_valid, s_req_len, s_req_mask, s_req_addr, s_req_we,
               s_write_valid, s_write_data, s_read_ack
    );

    modport master (
        output m_req_valid, m_req_len, m_req_mask, m_req_addr, m_req_we,
               m_write_valid, m_write_data, m_read_ack,
               s_req_ready, s_read_valid, s_read_data,
        input  m_req_ready, m_read_valid, m_read_data,
               s_req_valid, s_req_len, s_req_mask, s_req_addr, s_req_we,
               s_write_valid, s_write_data, s_read_ack
    );
endinterface

// File: rtl/mem_arbiter_req_latch.sv
// mem_arbiter_req_latch
// Holds one outstanding request for a single requester until the arbiter
// takes it. A new pulse while a request is already held is dropped so the
// first request wins.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   valid_i               one-cycle request pulse
//   clear_i               arbiter has granted the held request
//   len_i/mask_i/addr_i/we_i   request fields captured on valid_i
//   pending_o             a request is held
//   len_o/mask_o/addr_o/we_o   held request fields
module mem_arbiter_req_latch
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              clear_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [3:0]        mask_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    output logic              pending_o,
    output logic [LEN_W-1:0]  len_o,
    output logic [3:0]        mask_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o
);
    logic              pending_q, pending_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [3:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;

    // A grant empties the slot; a pulse only loads an empty slot. A pulse
    // coinciding with the grant cycle finds the slot still full and is
    // dropped.
    always_comb begin
        pending_d = pending_q;
        len_d     = len_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        we_d      = we_q;
        if (clear_i) begin
            pending_d = 1'b0;
        end else if (valid_i && !pending_q) begin
            pending_d = 1'b1;
            len_d     = len_i;
            mask_d    = mask_i;
            addr_d    = addr_i;
            we_d      = we_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            len_q     <= '0;
            mask_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            len_q     <= len_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
        end
    end

    assign pending_o = pending_q;
    assign len_o     = len_q;
    assign mask_o    = mask_q;
    assign addr_o    = addr_q;
    assign we_o      = we_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester arbiter in front of a single memory port. Requester 0 is
// the CPU bus interface, requester 1 an auxiliary fetcher. Each requester
// has one pending slot; the winner's request is issued downstream and its
// whole burst is routed through before the next decision.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   bus            mem_arbiter_if.slave (requester channels + memory port)
//   grant          one-hot current owner, 0 when idle
// Build option: ARB_RR_EN selects round-robin arbitration (last-granted
// requester loses ties); otherwise requester 0 always wins a tie.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
)(
    input  logic           clk_i,
    input  logic           rst_i,
    mem_arbiter_if.slave   bus,
    output logic [1:0]     grant
);
    logic [1:0]        pending;
    logic [1:0]        clear;
    logic [LEN_W-1:0]  pendLen  [2];
    logic [3:0]        pendMask [2];
    logic [ADDR_W-1:0] pendAddr [2];
    logic [1:0]        pendWe;

    genvar r;
    for (r = 0; r < 2; r++) begin : gLatch
        mem_arbiter_req_latch #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) uLatch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .valid_i   (bus.m_req_valid[r]),
            .clear_i   (clear[r]),
            .len_i     (bus.m_req_len[r*LEN_W +: LEN_W]),
            .mask_i    (bus.m_req_mask[r*4 +: 4]),
            .addr_i    (bus.m_req_addr[r*ADDR_W +: ADDR_W]),
            .we_i      (bus.m_req_we[r]),
            .pending_o (pending[r]),
            .len_o     (pendLen[r]),
            .mask_o    (pendMask[r]),
            .addr_o    (pendAddr[r]),
            .we_o      (pendWe[r])
        );
    end

    arbState_e         state_q;
    logic [1:0]        grant_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              sreqValid_q;
    logic [LEN_W-1:0]  sreqLen_q;
    logic [3:0]        sreqMask_q;
    logic [ADDR_W-1:0] sreqAddr_q;
    logic              sreqWe_q;
`ifdef ARB_RR_EN
    logic              last_q;
`endif

    logic [1:0] win;
    logic       winIdx;
    logic       inData;
    logic       beat;

    // Winner selection among pending requesters. On a tie the round-robin
    // build favours whoever was not granted last.
    always_comb begin
        win = 2'b00;
        if (pending == 2'b11) begin
`ifdef ARB_RR_EN
            win = last_q ? 2'b01 : 2'b10;
`else
            win = 2'b01;
`endif
        end else begin
            win = pending;
        end
    end

    assign winIdx = win[1];
    assign clear  = (state_q == IDLE) ? win : 2'b00;
    assign inData = (state_q == DATA);

    // A beat is a write strobe on write bursts or a read pop on read
    // bursts, from the owner only.
    assign beat = sreqWe_q ? |(bus.m_write_valid & grant_q)
                           : |(bus.m_read_ack & grant_q);

    // Arbitration FSM: grant in IDLE, hold the downstream request in REQ,
    // count beats in DATA and return to IDLE after the last one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            cnt_q       <= '0;
            sreqValid_q <= 1'b0;
            sreqLen_q   <= '0;
            sreqMask_q  <= '0;
            sreqAddr_q  <= '0;
            sreqWe_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pending) begin
                        grant_q     <= win;
                        sreqValid_q <= 1'b1;
                        sreqLen_q   <= pendLen[winIdx];
                        sreqMask_q  <= pendMask[winIdx];
                        sreqAddr_q  <= pendAddr[winIdx];
                        sreqWe_q    <= pendWe[winIdx];
`ifdef ARB_RR_EN
                        last_q      <= winIdx;
`endif
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.s_req_ready) begin
                        sreqValid_q <= 1'b0;
                        cnt_q       <= LEN_W'(beatCount(32'(sreqLen_q)));
                        state_q     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        if (cnt_q == LEN_W'(1)) begin
                            grant_q <= 2'b00;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                end
                default: begin
                    grant_q <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant          = grant_q;
    assign bus.s_req_valid = sreqValid_q;
    assign bus.s_req_len   = sreqLen_q;
    assign bus.s_req_mask  = sreqMask_q;
    assign bus.s_req_addr  = sreqAddr_q;
    assign bus.s_req_we    = sreqWe_q;

    // Data-phase routing follows the registered grant, so nothing leaks
    // through while idle, waiting for acceptance or held in reset.
    assign bus.m_req_ready   = inData ? grant_q : 2'b00;
    assign bus.s_write_valid = inData && sreqWe_q && |(bus.m_write_valid & grant_q);
    assign bus.s_write_data  = !inData ? '0 :
                               grant_q[1] ? bus.m_write_data[DATA_W +: DATA_W]
                                          : bus.m_write_data[0 +: DATA_W];
    assign bus.m_read_valid  = (inData && bus.s_read_valid) ? grant_q : 2'b00;
    assign bus.m_read_data   = inData ? bus.s_read_data : '0;
    assign bus.s_read_ack    = inData && !sreqWe_q && |(bus.m_read_ack & grant_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter: single read, burst write, tie-break,
// drop-if-pending, length-0 burst and asynchronous reset mid-burst.
module tb_mem_arbiter;
    logic clk_i;
    logic rst_i;
    logic [1:0] grant;
    int compared;
    int mismatched;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus),
        .grant (grant)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Moves to 1 time unit after the next rising edge, where inputs are
    // changed and outputs are sampled.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setReq(input int r, input logic [2:0] len,
                          input logic [31:0] addr, input logic we);
        bus.m_req_len[r*3 +: 3]   = len;
        bus.m_req_mask[r*4 +: 4]  = 4'hF;
        bus.m_req_addr[r*32 +: 32] = addr;
        bus.m_req_we[r]           = we;
    endtask

    task automatic waitReq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.s_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic acceptReq();
        bus.s_req_ready = 1'b1;
        tick();
        bus.s_req_ready = 1'b0;
    endtask

    task automatic readBeat(input logic [1:0] who, input logic [31:0] data);
        bus.s_read_valid = 1'b1;
        bus.s_read_data  = data;
        bus.m_read_ack   = who;
        tick();
        bus.s_read_valid = 1'b0;
        bus.m_read_ack   = 2'b00;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus.m_req_valid = '0; bus.m_req_len = '0; bus.m_req_mask = '0;
        bus.m_req_addr = '0; bus.m_req_we = '0; bus.m_write_valid = '0;
        bus.m_write_data = '0; bus.m_read_ack = '0; bus.s_req_ready = 1'b0;
        bus.s_read_valid = 1'b0; bus.s_read_data = '0;
        #2;
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("[TB] FAIL reset grant: got %b want 00", grant); end
        compared++;
        if (bus.s_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset s_req_valid: got %b want 0", bus.s_req_valid); end
        compared++;
        if (bus.m_req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL reset m_req_ready: got %b want 00", bus.m_req_ready); end
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_r0_read();
        bit ok;
        setReq(0, 3'd1, 32'h0000_1000, 1'b0);
        bus.m_req_valid = 2'b01;
        tick();
        bus.m_req_valid = 2'b00;
        compared++;
        if (bus.s_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL r0 early s_req_valid: got %b want 0", bus.s_req_valid); end
        tick();
        compared++;
        if (bus.s_req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL r0 s_req_valid latency: got %b want 1", bus.s_req_valid); end
        compared++;
        if (bus.s_req_addr !== 32'h0000_1000) begin mismatched++; $display("[TB] FAIL r0 s_req_addr: got %h want 00001000", bus.s_req_addr); end
        compared++;
        if (grant !== 2'b01) begin mismatched++; $display("[TB] FAIL r0 grant: got %b want 01", grant); end
        tick();
        waitReq(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL r0 s_req_valid held: got 0 want 1"); end
        acceptReq();
        compared++;
        if (bus.m_req_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL r0 m_req_ready: got %b want 01", bus.m_req_ready); end
        bus.s_read_valid = 1'b1;
        bus.s_read_data  = 32'hDEAD_BEEF;
        #1;
        compared++;
        if (bus.m_read_valid !== 2'b01) begin mismatched++; $display("[TB] FAIL r0 m_read_valid: got %b want 01", bus.m_read_valid); end
        compared++;
        if (bus.m_read_data !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL r0 m_read_data: got %h want deadbeef", bus.m_read_data); end
        bus.m_read_ack = 2'b01;
        #1;
        compared++;
        if (bus.s_read_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL r0 s_read_ack: got %b want 1", bus.s_read_ack); end
        tick();
        bus.m_read_ack = 2'b00;
        bus.s_read_valid = 1'b0;
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("[TB] FAIL r0 grant after ack: got %b want 00", grant); end
        compared++;
        if (bus.m_req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL r0 m_req_ready after ack: got %b want 00", bus.m_req_ready); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [1:0]  firstG, secondG;
        logic [31:0] firstA, secondA;
`ifdef ARB_RR_EN
        firstG = 2'b10; firstA = 32'h0000_00B0; secondG = 2'b01; secondA = 32'h0000_00A0;
`else
        firstG = 2'b01; firstA = 32'h0000_00A0; secondG = 2'b10; secondA = 32'h0000_00B0;
`endif
        setReq(0, 3'd1, 32'h0000_00A0, 1'b0);
        setReq(1, 3'd1, 32'h0000_00B0, 1'b0);
        bus.m_req_valid = 2'b11;
        tick();
        bus.m_req_valid = 2'b00;
        waitReq(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL tie first request: timed out"); end
        compared++;
        if (bus.s_req_addr !== firstA) begin mismatched++; $display("[TB] FAIL tie first addr: got %h want %h", bus.s_req_addr, firstA); end
        compared++;
        if (grant !== firstG) begin mismatched++; $display("[TB] FAIL tie first grant: got %b want %b", grant, firstG); end
        acceptReq();
        readBeat(firstG, 32'h0000_0001);
        waitReq(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL tie second request: timed out"); end
        compared++;
        if (bus.s_req_addr !== secondA) begin mismatched++; $display("[TB] FAIL tie second addr: got %h want %h", bus.s_req_addr, secondA); end
        compared++;
        if (grant !== secondG) begin mismatched++; $display("[TB] FAIL tie second grant: got %b want %b", grant, secondG); end
        acceptReq();
        bus.s_read_valid = 1'b1;
        #1;
        compared++;
        if (bus.m_read_valid !== secondG) begin mismatched++; $display("[TB] FAIL tie m_read_valid: got %b want %b", bus.m_read_valid, secondG); end
        readBeat(secondG, 32'h0000_0002);
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("[TB] FAIL tie grant idle: got %b want 00", grant); end
    endtask

    task automatic test_drop();
        bit ok;
        setReq(1, 3'd1, 32'h0000_3000, 1'b0);
        bus.m_req_valid = 2'b10;
        tick();
        setReq(1, 3'd1, 32'h0000_3333, 1'b0);
        tick();
        bus.m_req_valid = 2'b00;
        waitReq(ok);
        compared++;
        if (bus.s_req_addr !== 32'h0000_3000) begin mismatched++; $display("[TB] FAIL drop addr: got %h want 00003000", bus.s_req_addr); end
        acceptReq();
        readBeat(2'b10, 32'h0000_0003);
        for (int i = 0; i < 4; i++) tick();
        compared++;
        if (bus.s_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL drop second issue: got %b want 0", bus.s_req_valid); end
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("[TB] FAIL drop grant: got %b want 00", grant); end
    endtask

    task automatic test_r1_write();
        bit ok;
        logic [31:0] expData;
        setReq(1, 3'd4, 32'h0000_2000, 1'b1);
        bus.m_req_valid = 2'b10;
        tick();
        bus.m_req_valid = 2'b00;
        waitReq(ok);
        compared++;
        if (bus.s_req_len !== 3'd4) begin mismatched++; $display("[TB] FAIL wr s_req_len: got %0d want 4", bus.s_req_len); end
        compared++;
        if (bus.s_req_we !== 1'b1) begin mismatched++; $display("[TB] FAIL wr s_req_we: got %b want 1", bus.s_req_we); end
        compared++;
        if (grant !== 2'b10) begin mismatched++; $display("[TB] FAIL wr grant: got %b want 10", grant); end
        bus.m_write_valid = 2'b10;
        bus.m_write_data  = {32'h0000_0099, 32'h0};
        #1;
        compared++;
        if (bus.s_write_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL wr strobe in REQ: got %b want 0", bus.s_write_valid); end
        bus.m_write_valid = 2'b00;
        acceptReq();
        for (int i = 0; i < 4; i++) begin
            expData = 32'h11 * (i + 1);
            compared++;
            if (bus.m_req_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL wr m_req_ready beat %0d: got %b want 10", i, bus.m_req_ready); end
            bus.m_write_valid = 2'b11;
            bus.m_write_data  = {expData, 32'hBAD0_BAD0};
            if (i == 3) begin
                setReq(1, 3'd0, 32'h0000_4000, 1'b1);
                bus.m_req_valid = 2'b10;
            end
            #1;
            compared++;
            if (bus.s_write_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wr s_write_valid beat %0d: got %b want 1", i, bus.s_write_valid); end
            compared++;
            if (bus.s_write_data !== expData) begin mismatched++; $display("[TB] FAIL wr s_write_data beat %0d: got %h want %h", i, bus.s_write_data, expData); end
            tick();
        end
        bus.m_write_valid = 2'b00;
        bus.m_req_valid   = 2'b00;
        compared++;
        if (bus.m_req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL wr m_req_ready after burst: got %b want 00", bus.m_req_ready); end
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("[TB] FAIL wr grant after burst: got %b want 00", grant); end
    endtask

    task automatic test_len_zero();
        bit ok;
        waitReq(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL len0 request: timed out"); end
        compared++;
        if (bus.s_req_addr !== 32'h0000_4000) begin mismatched++; $display("[TB] FAIL len0 addr: got %h want 00004000", bus.s_req_addr); end
        compared++;
        if (bus.s_req_len !== 3'd0) begin mismatched++; $display("[TB] FAIL len0 s_req_len: got %0d want 0", bus.s_req_len); end
        acceptReq();
        bus.m_write_valid = 2'b10;
        bus.m_write_data  = {32'h0000_0055, 32'h0};
        #1;
        compared++;
        if (bus.s_write_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL len0 s_write_valid: got %b want 1", bus.s_write_valid); end
        tick();
        bus.m_write_valid = 2'b00;
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("[TB] FAIL len0 grant: got %b want 00", grant); end
        compared++;
        if (bus.m_req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL len0 m_req_ready: got %b want 00", bus.m_req_ready); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        setReq(0, 3'd4, 32'h0000_5000, 1'b0);
        bus.m_req_valid = 2'b01;
        tick();
        bus.m_req_valid = 2'b00;
        waitReq(ok);
        acceptReq();
        readBeat(2'b01, 32'h0000_0010);
        readBeat(2'b01, 32'h0000_0020);
        setReq(1, 3'd1, 32'h0000_6000, 1'b0);
        bus.m_req_valid = 2'b10;
        tick();
        bus.m_req_valid = 2'b00;
        bus.s_read_valid = 1'b1;
        bus.s_read_data  = 32'h0000_1234;
        bus.m_read_ack   = 2'b01;
        #1;
        compared++;
        if (bus.m_read_valid !== 2'b01) begin mismatched++; $display("[TB] FAIL mid m_read_valid before reset: got %b want 01", bus.m_read_valid); end
        rst_i = 1'b1;
        #1;
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("[TB] FAIL mid reset grant: got %b want 00", grant); end
        compared++;
        if (bus.m_req_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL mid reset m_req_ready: got %b want 00", bus.m_req_ready); end
        compared++;
        if (bus.m_read_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL mid reset m_read_valid: got %b want 00", bus.m_read_valid); end
        compared++;
        if (bus.s_read_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL mid reset s_read_ack: got %b want 0", bus.s_read_ack); end
        bus.s_read_valid = 1'b0;
        bus.m_read_ack   = 2'b00;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        compared++;
        if (bus.s_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid pending after reset: got %b want 0", bus.s_req_valid); end
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("[TB] FAIL mid grant after reset: got %b want 00", grant); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_r0_read();
        test_simultaneous();
        test_drop();
        test_r1_write();
        test_len_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
